// File: rtl/mult_job_feeder.sv
// Operand FIFO plus job sequencer for the repeated-addition multiplier:
// issues one job at a time, waits mul_b+SETTLE cycles, then hands the product downstream.
module mult_job_feeder #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_a,
   input  logic [7:0]             in_b,
   output logic [7:0]             mul_a,
   output logic [7:0]             mul_b,
   output logic                   mul_start,
   input  logic [15:0]            mul_p,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [15:0]            out_p,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic [15:0]    r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;

   logic [7:0]     r_mul_a;
   logic [7:0]     r_mul_b;
   logic [8:0]     r_cnt;
   logic           r_out_valid;
   logic [15:0]    r_out_p;

   logic           w_in_ready;
   logic           w_push;
   logic           w_pop;
   logic           w_start;
   logic           w_busy;
   logic           w_count_down;
   logic           w_capture;
   logic           w_release;
   logic [15:0]    w_head;

   // in_ready looks only at occupancy, never at a same-cycle pop
   assign w_in_ready = (r_count < CW'(DEPTH));
   assign w_push     = in_valid & w_in_ready;
   assign w_head     = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_a, in_b};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_state_next = S_START;
         S_START: w_state_next = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_state_next = S_HOLD;
         S_HOLD:  if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop        = 1'b0;
      w_start      = 1'b0;
      w_busy       = 1'b1;
      w_count_down = 1'b0;
      w_capture    = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            w_pop  = (r_count != '0);
         end
         S_START: w_start = 1'b1;
         S_WAIT: begin
            w_count_down = (r_cnt != '0);
            w_capture    = (r_cnt == '0);
         end
         S_HOLD:  w_release = out_ready;
         default: w_busy = 1'b1;
      endcase
   end

   // Operands stay put from pop until the next pop, so the multiplier sees them through HOLD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_p     <= '0;
      end else begin
         if (w_pop) begin
            r_mul_a <= w_head[15:8];
            r_mul_b <= w_head[7:0];
         end
         if (w_start) begin
            r_cnt <= {1'b0, r_mul_b} + 9'(SETTLE);
         end else if (w_count_down) begin
            r_cnt <= r_cnt - 9'd1;
         end
         if (w_capture) begin
            r_out_p     <= mul_p;
            r_out_valid <= 1'b1;
         end else if (w_release) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;
   assign mul_start  = w_start;
   assign out_valid  = r_out_valid;
   assign out_p      = r_out_p;
   assign busy       = w_busy;
   assign fifo_count = r_count;

endmodule
